// File: rtl/i2c_reg_slave.sv
// ============================================================================
// i2c_reg_slave
// ----------------------------------------------------------------------------
// I2C target with a 2**REG_AW x 8 register file. An I2C master accesses it
// through the split-pin open-drain interface. The local side has a direct
// read/write port. The target supports a pointer write, pointer
// auto-increment, repeated START and glitch filtering on both bus lines.
// SCL is never stretched.
//
// Parameters
//   DEV_ADDR    7-bit target address
//   REG_AW      register pointer width (1..8), depth = 2**REG_AW
//   FILTER_LEN  consecutive equal raw samples (>=2) needed to move a filter
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   enable               bus participation, sampled when a START is seen
//   scl_i/scl_o/scl_t    SCL pin (output tied 0, tristate tied 1)
//   sda_i/sda_o/sda_t    SDA pin (sda_o tied 0, sda_t=0 pulls the line low)
//   loc_we/loc_addr/loc_wdata/loc_rdata
//                        local register port (combinational read)
//   wr_valid/wr_addr/wr_data
//                        one-cycle report of each register written over I2C
//   busy                 address-matched transfer in progress
// ============================================================================
module i2c_reg_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'h5a,
    parameter int         REG_AW     = 4,
    parameter int         FILTER_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              scl_i,
    output logic              scl_o,
    output logic              scl_t,
    input  logic              sda_i,
    output logic              sda_o,
    output logic              sda_t,
    input  logic              loc_we,
    input  logic [REG_AW-1:0] loc_addr,
    input  logic [7:0]        loc_wdata,
    output logic [7:0]        loc_rdata,
    output logic              wr_valid,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int                DEPTH   = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK
    } state_t;

    // ------------------------------------------------------------------------
    // Input filters and edge detection
    // ------------------------------------------------------------------------
    logic [FILTER_LEN-1:0] scl_hist_q, sda_hist_q;
    logic                  scl_f_q, sda_f_q;
    logic                  scl_prev_q, sda_prev_q;

    // A filtered line follows the raw pin only after the sample history
    // is uniformly at the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[FILTER_LEN-2:0], scl_i};
            sda_hist_q <= {sda_hist_q[FILTER_LEN-2:0], sda_i};
            if (&scl_hist_q)       scl_f_q <= 1'b1;
            else if (~|scl_hist_q) scl_f_q <= 1'b0;
            if (&sda_hist_q)       sda_f_q <= 1'b1;
            else if (~|sda_hist_q) sda_f_q <= 1'b0;
            scl_prev_q <= scl_f_q;
            sda_prev_q <= sda_f_q;
        end
    end

    logic scl_rise, scl_fall, start_cond, stop_cond;

    always_comb begin
        scl_rise   = scl_f_q & ~scl_prev_q;
        scl_fall   = ~scl_f_q & scl_prev_q;
        // SCL must be high both before and after the SDA transition.
        start_cond = ~sda_f_q & sda_prev_q & scl_f_q & scl_prev_q;
        stop_cond  = sda_f_q & ~sda_prev_q & scl_f_q & scl_prev_q;
    end

    // ------------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------------
    logic [7:0]        regs_q [DEPTH];
    logic              i2c_we;
    logic [REG_AW-1:0] i2c_waddr;
    logic [7:0]        i2c_wdata;

    // The local write comes last, so it wins when both target one address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
        end else begin
            if (i2c_we) regs_q[i2c_waddr] <= i2c_wdata;
            if (loc_we) regs_q[loc_addr]  <= loc_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Protocol FSM: state register
    // ------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              sda_oe_q, sda_oe_d;
    logic              rw_q, rw_d;
    logic              got_ack_q, got_ack_d;
    logic              busy_q, busy_d;
    logic              wr_valid_q, wr_valid_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            got_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            got_ack_q  <= got_ack_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Protocol FSM: next state
    // ------------------------------------------------------------------------
    logic [7:0] rx_byte;

    always_comb begin
        rx_byte    = {shift_q[6:0], sda_f_q};
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        got_ack_d  = got_ack_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        i2c_we     = 1'b0;
        i2c_waddr  = ptr_q;
        i2c_wdata  = rx_byte;

        if (stop_cond) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            bitcnt_d = 3'd0;
        end else if (start_cond) begin
            // A repeated START keeps busy and the pointer.
            // enable is only consulted here.
            state_d   = enable ? S_ADDR : S_IDLE;
            busy_d    = enable ? busy_q : 1'b0;
            sda_oe_d  = 1'b0;
            bitcnt_d  = 3'd0;
            got_ack_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: ;

                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                rw_d    = rx_byte[0];
                                busy_d  = 1'b1;
                                state_d = S_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = S_IDLE;
                            end
                        end
                    end
                end

                // The first SCL fall after the 8th bit starts the ACK pull.
                // The second fall (end of the 9th clock) releases the line.
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = 3'd0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                // This fall is also the first fall of
                                // the read byte, so latch and drive the MSB.
                                shift_d  = regs_q[ptr_q];
                                sda_oe_d = ~regs_q[ptr_q][7];
                                state_d  = S_RD;
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WR;
                            end
                        end
                    end
                end

                S_PTR: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            ptr_d   = rx_byte[REG_AW-1:0];
                            state_d = S_PTR_ACK;
                        end
                    end
                end

                S_WR: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            i2c_we     = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = rx_byte;
                            ptr_d      = ptr_q + PTR_ONE;
                            state_d    = S_WR_ACK;
                        end
                    end
                end

                // The MSB went out on entry. Each later fall advances one bit.
                // The fall after bit 0 hands SDA to the master.
                S_RD: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            bitcnt_d  = 3'd0;
                            got_ack_d = 1'b0;
                            state_d   = S_RD_ACK;
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end

                S_RD_ACK: begin
                    if (scl_rise && !got_ack_q) begin
                        ptr_d = ptr_q + PTR_ONE;
                        if (sda_f_q) begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            got_ack_d = 1'b1;
                        end
                    end else if (scl_fall && got_ack_q) begin
                        shift_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                        bitcnt_d  = 3'd0;
                        got_ack_d = 1'b0;
                        state_d   = S_RD;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Protocol FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        scl_o     = 1'b0;
        scl_t     = 1'b1;
        sda_o     = 1'b0;
        sda_t     = ~sda_oe_q;
        busy      = busy_q;
        wr_valid  = wr_valid_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        loc_rdata = regs_q[loc_addr];
    end

endmodule
